// File: rtl/image_fetch.sv
// image_fetch
//   Walks square convolution windows over a zero-padded feature map and issues
//   one memory word read per in-image element. Padding elements issue no read
//   and produce an all-zero word. Every element travels through a tag pipe that
//   is as deep as the memory read latency, so the output order is the scan order.
//   Results are queued in a credit-limited buffer with a valid/ready output.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cfg_data/addr/valid config register write port (accepted only in IDLE)
//   next, next_rdy      start one image pass / idle indicator
//   done                one-cycle pulse once the last word has left the buffer
//   rd_val, rd_addr     memory read request
//   rd_data             read data, valid RD_LATENCY cycles after rd_val
//   image_bus/last/val  output word, last-of-window flag, valid
//   image_rdy           output ready
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for next; config writes allowed
// BUSY  | issuing one element per cycle while credits are available
// DRAIN | all elements issued; wait for tag pipe and buffer to empty

module image_fetch #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int RD_LATENCY = 3,
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16,
    parameter int MEM_AWIDTH = 16,
    parameter int BUF_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic                          next,
    output logic                          next_rdy,
    output logic                          done,
    output logic                          rd_val,
    output logic [MEM_AWIDTH-1:0]         rd_addr,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] rd_data,
    output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    output logic                          image_last,
    output logic                          image_val,
    input  logic                          image_rdy
);

    localparam int DW  = GROUP_NB * IMG_WIDTH;
    localparam int PW  = 18;                       // holds padded extents up to 65536+510
    localparam int BAW = $clog2(BUF_DEPTH);
    localparam int CW  = $clog2(BUF_DEPTH) + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DRAIN
    } state_t;

    state_t state, state_nx;
    logic   load, issue;

    // ---------------- configuration registers ----------------
    logic [15:0]           cfg_w_m1, cfg_h_m1, cfg_d_m1;
    logic [7:0]            cfg_pad_l, cfg_pad_r, cfg_pad_t, cfg_pad_b;
    logic [7:0]            cfg_side_m1, cfg_step_m1;
    logic [MEM_AWIDTH-1:0] cfg_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_w_m1    <= '0;
            cfg_h_m1    <= '0;
            cfg_d_m1    <= '0;
            cfg_pad_l   <= '0;
            cfg_pad_r   <= '0;
            cfg_pad_t   <= '0;
            cfg_pad_b   <= '0;
            cfg_side_m1 <= '0;
            cfg_step_m1 <= '0;
            cfg_base    <= '0;
        end else if (cfg_valid && state == S_IDLE) begin
            case (cfg_addr)
                CFG_AWIDTH'(0): cfg_w_m1 <= cfg_data[15:0];
                CFG_AWIDTH'(1): begin
                    cfg_d_m1 <= cfg_data[31:16];
                    cfg_h_m1 <= cfg_data[15:0];
                end
                CFG_AWIDTH'(2): begin
                    cfg_pad_l <= cfg_data[31:24];
                    cfg_pad_r <= cfg_data[23:16];
                    cfg_pad_t <= cfg_data[15:8];
                    cfg_pad_b <= cfg_data[7:0];
                end
                CFG_AWIDTH'(3): begin
                    cfg_side_m1 <= cfg_data[15:8];
                    cfg_step_m1 <= cfg_data[7:0];
                end
                CFG_AWIDTH'(4): cfg_base <= cfg_data[MEM_AWIDTH-1:0];
                default: ;
            endcase
        end
    end

    // ---------------- per-pass snapshot ----------------
    logic [PW-1:0] c_w, c_h, c_wp, c_hp, c_side;
    assign c_w    = PW'(cfg_w_m1) + PW'(1);
    assign c_h    = PW'(cfg_h_m1) + PW'(1);
    assign c_side = PW'(cfg_side_m1) + PW'(1);
    assign c_wp   = c_w + PW'(cfg_pad_l) + PW'(cfg_pad_r);
    assign c_hp   = c_h + PW'(cfg_pad_t) + PW'(cfg_pad_b);

    logic [PW-1:0]         s_w, s_h, s_d, s_wp, s_hp, s_side, s_step, s_pad_l, s_pad_t;
    logic [15:0]           s_d_m1;
    logic [7:0]            s_side_m1;
    logic [MEM_AWIDTH-1:0] s_base;
    logic                  s_degen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_w       <= '0;
            s_h       <= '0;
            s_d       <= '0;
            s_wp      <= '0;
            s_hp      <= '0;
            s_side    <= '0;
            s_step    <= '0;
            s_pad_l   <= '0;
            s_pad_t   <= '0;
            s_d_m1    <= '0;
            s_side_m1 <= '0;
            s_base    <= '0;
            s_degen   <= 1'b0;
        end else if (load) begin
            s_w       <= c_w;
            s_h       <= c_h;
            s_d       <= PW'(cfg_d_m1) + PW'(1);
            s_wp      <= c_wp;
            s_hp      <= c_hp;
            s_side    <= c_side;
            s_step    <= PW'(cfg_step_m1) + PW'(1);
            s_pad_l   <= PW'(cfg_pad_l);
            s_pad_t   <= PW'(cfg_pad_t);
            s_d_m1    <= cfg_d_m1;
            s_side_m1 <= cfg_side_m1;
            s_base    <= cfg_base;
            s_degen   <= (c_side > c_wp) || (c_side > c_hp);
        end
    end

    // ---------------- scan counters ----------------
    logic [PW-1:0] x0, y0;
    logic [7:0]    kx, ky;
    logic [15:0]   d_idx;

    logic d_wrap, kx_wrap, ky_wrap, x_more, y_more, elem_last, final_elem;
    assign d_wrap     = (d_idx == s_d_m1);
    assign kx_wrap    = (kx == s_side_m1);
    assign ky_wrap    = (ky == s_side_m1);
    assign x_more     = (x0 + s_step + s_side) <= s_wp;
    assign y_more     = (y0 + s_step + s_side) <= s_hp;
    assign elem_last  = d_wrap && kx_wrap && ky_wrap;
    assign final_elem = elem_last && !x_more && !y_more;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0    <= '0;
            y0    <= '0;
            kx    <= '0;
            ky    <= '0;
            d_idx <= '0;
        end else if (load) begin
            x0    <= '0;
            y0    <= '0;
            kx    <= '0;
            ky    <= '0;
            d_idx <= '0;
        end else if (issue) begin
            if (!d_wrap) begin
                d_idx <= d_idx + 16'd1;
            end else begin
                d_idx <= '0;
                if (!kx_wrap) begin
                    kx <= kx + 8'd1;
                end else begin
                    kx <= '0;
                    if (!ky_wrap) begin
                        ky <= ky + 8'd1;
                    end else begin
                        ky <= '0;
                        if (x_more) begin
                            x0 <= x0 + s_step;
                        end else begin
                            x0 <= '0;
                            y0 <= y0 + s_step;
                        end
                    end
                end
            end
        end
    end

    // Position in padded coordinates; inside the image when within [pad, pad+size).
    logic [PW-1:0]         xs, ys, px, py;
    logic                  is_pad;
    logic [MEM_AWIDTH-1:0] elem_addr;
    assign xs     = x0 + PW'(kx);
    assign ys     = y0 + PW'(ky);
    assign px     = xs - s_pad_l;
    assign py     = ys - s_pad_t;
    assign is_pad = !((xs >= s_pad_l) && (xs < s_pad_l + s_w) &&
                      (ys >= s_pad_t) && (ys < s_pad_t + s_h));
    // Arithmetic modulo 2^32 then truncated; the address wraps in MEM_AWIDTH bits.
    assign elem_addr = s_base + MEM_AWIDTH'((32'(py) * 32'(s_w) + 32'(px)) * 32'(s_d) + 32'(d_idx));

    assign rd_val  = issue && !is_pad;
    assign rd_addr = rd_val ? elem_addr : '0;

    // ---------------- tag pipe ----------------
    logic [RD_LATENCY-1:0] pipe_vld, pipe_pad, pipe_last;
    logic [CW-1:0]         inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld  <= '0;
            pipe_pad  <= '0;
            pipe_last <= '0;
        end else begin
            pipe_vld[0]  <= issue;
            pipe_pad[0]  <= is_pad;
            pipe_last[0] <= elem_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_pad[i]  <= pipe_pad[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, pipe_vld[RD_LATENCY-1]})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: ;
            endcase
        end
    end

    // ---------------- output buffer ----------------
    logic [DW-1:0]  buf_data [BUF_DEPTH];
    logic           buf_last [BUF_DEPTH];
    logic [BAW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]  occ;
    logic           push, pop, credit_ok;

    assign push      = pipe_vld[RD_LATENCY-1];
    assign pop       = image_val && image_rdy;
    // Elements in flight already own a buffer slot, so the buffer cannot overflow.
    assign credit_ok = (occ + inflight) < CW'(BUF_DEPTH);

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= pipe_pad[RD_LATENCY-1] ? '0 : rd_data;
            buf_last[wr_ptr] <= pipe_last[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + BAW'(1);
            if (pop)  rd_ptr <= rd_ptr + BAW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: ;
            endcase
        end
    end

    assign image_val  = (occ != '0);
    assign image_bus  = image_val ? buf_data[rd_ptr] : '0;
    assign image_last = image_val ? buf_last[rd_ptr] : 1'b0;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        issue    = 1'b0;
        done     = 1'b0;
        next_rdy = 1'b0;
        case (state)
            S_IDLE: begin
                next_rdy = 1'b1;
                if (next) begin
                    load     = 1'b1;
                    state_nx = S_BUSY;
                end
            end
            S_BUSY: begin
                if (s_degen) begin
                    state_nx = S_DRAIN;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (final_elem) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (inflight == '0 && occ == '0) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
